// File: rtl/uart_frame_parser_if.sv
// Byte-in / frame-event-out bundle between the UART receiver, the frame parser
// and the command layer. The master side feeds bytes; the slave side (parser) reports.
interface uart_frame_parser_if;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       payload_valid;
  logic [7:0] payload_data;
  logic [7:0] payload_idx;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    output uart_rx_done, uart_rx_data,
    input  payload_valid, payload_data, payload_idx, frame_ok, frame_err, err_code
  );

  modport slave (
    input  uart_rx_done, uart_rx_data,
    output payload_valid, payload_data, payload_idx, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses 0xA5, LEN, payload[LEN], CHK frames from received UART bytes.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned SYS_CLK     = 50000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned TIMEOUT_CYC = (SYS_CLK / BAUD_RATE) * 20
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_frame_parser_if.slave bus
);

  if (MAX_LEN == 0 || MAX_LEN > 32'd255) begin : g_bad_max_len
    $error("MAX_LEN must be in 1..255");
  end
  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC >= 32'd16777216) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..2^24-1");
  end

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0] HDR       = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK} state_t;

  state_t     state_q;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic [7:0] chk_q;
  logic       pvalid_q;
  logic [7:0] pdata_q;
  logic [7:0] pidx_q;
  logic       ok_q;
  logic       err_q;
  logic [1:0] code_q;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [23:0] GAP_LAST = 24'(TIMEOUT_CYC - 1);
  logic [23:0] gap_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      pvalid_q <= 1'b0;
      pdata_q  <= '0;
      pidx_q   <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
      gap_q    <= '0;
`endif
    end else begin
      pvalid_q <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      if (bus.uart_rx_done) begin
`ifdef UART_FRAME_TIMEOUT_EN
        // An arriving byte always beats a coincident timeout.
        gap_q <= '0;
`endif
        unique case (state_q)
          S_IDLE: begin
            if (bus.uart_rx_data == HDR) state_q <= S_LEN;
          end
          S_LEN: begin
            if (bus.uart_rx_data == 8'd0 || bus.uart_rx_data > MAX_LEN_B) begin
              err_q   <= 1'b1;
              code_q  <= 2'd1;
              state_q <= S_IDLE;
            end else begin
              len_q   <= bus.uart_rx_data;
              chk_q   <= bus.uart_rx_data;
              idx_q   <= '0;
              state_q <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            pvalid_q <= 1'b1;
            pdata_q  <= bus.uart_rx_data;
            pidx_q   <= idx_q;
            chk_q    <= chk_q ^ bus.uart_rx_data;
            idx_q    <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= S_CHK;
          end
          S_CHK: begin
            if (bus.uart_rx_data == chk_q) begin
              ok_q <= 1'b1;
            end else begin
              err_q  <= 1'b1;
              code_q <= 2'd2;
            end
            state_q <= S_IDLE;
          end
        endcase
      end
`ifdef UART_FRAME_TIMEOUT_EN
      else if (state_q == S_IDLE) begin
        gap_q <= '0;
      end else if (gap_q == GAP_LAST) begin
        err_q   <= 1'b1;
        code_q  <= 2'd3;
        state_q <= S_IDLE;
        gap_q   <= '0;
      end else begin
        gap_q <= gap_q + 24'd1;
      end
`endif
    end
  end

  assign bus.payload_valid = pvalid_q;
  assign bus.payload_data  = pdata_q;
  assign bus.payload_idx   = pidx_q;
  assign bus.frame_ok      = ok_q;
  assign bus.frame_err     = err_q;
  assign bus.err_code      = code_q;

endmodule
